pc_gen: RTL
===========

# pc_gen

Parametrised fetch program-counter generator for the five-stage pipeline; the next generation of the plain stall-holding PC register. It holds the fetch PC, advances it sequentially and accepts branch and trap redirects. Redirects that arrive while fetch is stalled are parked, not lost, and are applied on the first unstalled cycle. It also flags misaligned branch targets and emits a one-cycle pulse whenever the PC was loaded from a redirect, so that downstream flush logic can use it.

## Interface
- PC_WIDTH, 64, width of all PC/target buses
- RESET_VECTOR, 0, value loaded into PC on reset
- INSTR_BYTES, 4, sequential increment (legal: 2 or 4)
- ALIGN_BITS, 2, low target bits that must be zero for a legal branch target (legal: 1 or 2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC; no update this cycle
- br_taken  in  1  branch/jump redirect request from EX
- br_target  in  PC_WIDTH  redirect address for br_taken
- trap  in  1  trap redirect request (exception/interrupt)
- trap_vector  in  PC_WIDTH  trap handler address; low ALIGN_BITS are forced to zero internally
- pc_out  out  PC_WIDTH  current fetch PC (registered)
- pc_plus  out  PC_WIDTH  pc_out + INSTR_BYTES (combinational, modulo 2^PC_WIDTH)
- redirect_pending  out  1  a parked redirect exists (registered)
- redirected  out  1  registered pulse: pc_out was loaded from a redirect on the last edge
- br_misaligned  out  1  registered pulse: a br_taken with misaligned target was seen

## Operation
- Pending state machine states: RUN (nothing parked), HOLD_BR (branch parked), HOLD_TRAP (trap parked); pend_addr register holds the parked address.
- stall=1:
  - pc_out holds.
  - Live trap -> HOLD_TRAP, pend_addr = aligned trap_vector; this overwrites any parked branch or trap.
  - Else a live legal br_taken while in RUN or HOLD_BR -> HOLD_BR, pend_addr = br_target (latest branch wins).
  - Else a live legal br_taken while in HOLD_TRAP is ignored.
- stall=0: pc_out is loaded by priority:
  - live trap, then HOLD_TRAP, then live legal br_taken, then HOLD_BR, then pc_plus.
  - The state machine returns to RUN.
  - redirected=1 if any of the first four sources was used, else 0.
- Legal target: br_target[ALIGN_BITS-1:0]==0. An illegal br_taken:
  - is never applied or parked;
  - sets br_misaligned=1 on the next edge, independent of stall;
  - leaves PC to follow the remaining priorities.
- Sequential arithmetic wraps: pc_out = 2^PC_WIDTH - INSTR_BYTES advances to 0.
- redirect_pending = (state != RUN).

## Timing
- Reset (async, immediate):
  - pc_out = RESET_VECTOR;
  - state RUN, pend_addr = 0;
  - redirect_pending = 0, redirected = 0, br_misaligned = 0.
- First rising edge after rst release with stall=0 loads RESET_VECTOR+INSTR_BYTES (absent redirects).
- Redirect latency:
  - Live redirect with stall=0: visible on pc_out one edge later.
  - Parked redirect: visible one edge after stall falls.
- redirected and br_misaligned are single-cycle pulses; both are 0 on any edge without a qualifying event.
- rst asserted mid-stall or with a parked redirect discards the parked redirect; pc_out returns to RESET_VECTOR.
- Simultaneous trap and br_taken in the same cycle: trap wins. The branch is dropped, but its misalignment is still flagged.

## Test plan
- Reset/sequential: RESET_VECTOR=0x1000, stall=0 for 3 edges -> pc_out 0x1000, 0x1004, 0x1008, 0x100C; redirected=0 throughout.
- Stall hold and park: at pc_out=0x2000, stall=1 with br_taken=1, br_target=0x3000 for one cycle, stall=1 two more cycles -> pc_out stays 0x2000, redirect_pending=1. Drop stall -> pc_out=0x3000, redirected=1 for one cycle, redirect_pending=0.
- Trap overrides parked branch: park branch 0x3000, then trap=1 with trap_vector=0x8003 while stalled -> parked addr 0x8000. Release stall -> pc_out=0x8000. A later stalled br_taken to 0x4000 while in HOLD_TRAP is ignored.
- Simultaneous, unstalled: trap=1 (vector 0x100) and br_taken=1 (target 0x200) in the same cycle -> pc_out=0x100, redirected=1.
- Misaligned: br_target=0x2002, ALIGN_BITS=2, stall=0, pc_out=0x500 -> pc_out=0x504, br_misaligned=1 for one cycle, nothing parked.
- Wrap and async reset: PC_WIDTH=64, pc_out=0xFFFF_FFFF_FFFF_FFFC -> next 0x0. Assert rst mid-cycle while HOLD_BR -> pc_out=RESET_VECTOR immediately, redirect_pending=0.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch program-counter generator.
// Holds the fetch PC and advances it by INSTR_BYTES each unstalled cycle.
// Accepts branch and trap redirects. A redirect that arrives while fetch is
// stalled is parked and applied on the first unstalled cycle. Misaligned
// branch targets are flagged, and every redirect-sourced load produces a
// one-cycle pulse for downstream flush logic.
module pc_gen #(
  parameter int                    PC_WIDTH     = 64,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
  parameter int                    INSTR_BYTES  = 4,
  parameter int                    ALIGN_BITS   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                br_taken,
  input  logic [PC_WIDTH-1:0] br_target,
  input  logic                trap,
  input  logic [PC_WIDTH-1:0] trap_vector,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [PC_WIDTH-1:0] pc_plus,
  output logic                redirect_pending,
  output logic                redirected,
  output logic                br_misaligned
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HOLD_BR   = 2'd1,
    HOLD_TRAP = 2'd2
  } pend_state_t;

  // Low-bit mask covering the bits that must be zero in a legal target.
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK =
    (PC_WIDTH'(1) << ALIGN_BITS) - PC_WIDTH'(1);
  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(INSTR_BYTES);

  // Clears the alignment bits of an address.
  function automatic logic [PC_WIDTH-1:0] align_down(input logic [PC_WIDTH-1:0] a);
    return a & ~ALIGN_MASK;
  endfunction

  // True when the alignment bits of an address are all zero.
  function automatic logic is_aligned(input logic [PC_WIDTH-1:0] a);
    return (a & ALIGN_MASK) == '0;
  endfunction

  pend_state_t         state, state_nxt;
  logic [PC_WIDTH-1:0] pend_addr, pend_addr_nxt;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic                redirected_nxt;
  logic                br_legal;
  logic                br_bad;
  logic [PC_WIDTH-1:0] trap_addr;

  assign br_legal  = br_taken && is_aligned(br_target);
  assign br_bad    = br_taken && !is_aligned(br_target);
  assign trap_addr = align_down(trap_vector);
  assign pc_plus   = pc_out + STEP;
  assign redirect_pending = (state != RUN);

  // Next PC, parking decision and redirect pulse for this cycle.
  always_comb begin
    state_nxt      = state;
    pend_addr_nxt  = pend_addr;
    pc_nxt         = pc_out;
    redirected_nxt = 1'b0;
    if (stall) begin
      // A trap always claims the park slot; a branch cannot displace a trap.
      if (trap) begin
        state_nxt     = HOLD_TRAP;
        pend_addr_nxt = trap_addr;
      end else if (br_legal && (state != HOLD_TRAP)) begin
        state_nxt     = HOLD_BR;
        pend_addr_nxt = br_target;
      end
    end else begin
      state_nxt      = RUN;
      redirected_nxt = 1'b1;
      if (trap) begin
        pc_nxt = trap_addr;
      end else if (state == HOLD_TRAP) begin
        pc_nxt = pend_addr;
      end else if (br_legal) begin
        pc_nxt = br_target;
      end else if (state == HOLD_BR) begin
        pc_nxt = pend_addr;
      end else begin
        pc_nxt         = pc_plus;
        redirected_nxt = 1'b0;
      end
    end
  end

  // State, parked address, PC and status pulses; async reset discards any park.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      pend_addr     <= '0;
      pc_out        <= RESET_VECTOR;
      redirected    <= 1'b0;
      br_misaligned <= 1'b0;
    end else begin
      state         <= state_nxt;
      pend_addr     <= pend_addr_nxt;
      pc_out        <= pc_nxt;
      redirected    <= redirected_nxt;
      br_misaligned <= br_bad;
    end
  end

endmodule
